bcd_timer_encoder: RTL



---
 rtl/bcd_timer_encoder_pkg.sv | 23 ++
 rtl/bcd_timer_encoder_digit.sv | 42 ++++
 rtl/bcd_timer_encoder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bcd_timer_encoder_pkg.sv
// Shared types and helpers for the VFSD reaction-timer datapath.
//   timer_state_t : start/stop FSM encoding (IDLE, RUN, HOLD, OVF)
//   bcd_digit_t   : one BCD digit, legal range 0..BCD_MAX
//   calc_div      : clock cycles per count tick (freq / tick rate)
package vfsd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        OVF
    } timer_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // A zero tick rate returns 0 so the caller's DIV >= 2 check rejects it.
    function automatic int unsigned calc_div(input int unsigned freq, input int unsigned tick);
        return (tick == 0) ? 0 : freq / tick;
    endfunction

endpackage

// File: rtl/bcd_timer_encoder_digit.sv
// One registered BCD digit of the elapsed-time counter.
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset, digit -> 0
//   clr       : synchronous clear (wins over inc)
//   inc       : advance digit by one, 9 wraps to 0
//   digit     : current digit value (0..9)
//   carry_out : combinational, inc while digit is 9 (feeds next digit's inc)
module bcd_digit_counter
    import vfsd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output bcd_digit_t digit,
    output logic       carry_out
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign carry_out = inc & (digit_q == BCD_MAX);

endmodule

// File: rtl/bcd_timer_encoder.sv
// 4-digit BCD elapsed-time counter with start/stop FSM. Counts prescaled
// ticks while running, saturates at 9999 and reports overflow.
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   start    : one-cycle pulse, clear digits and begin timing
//   stop     : one-cycle pulse, freeze count
//   cont_3..0: BCD digits, thousands..units
//   arm      : 1 while display should follow digits (RUN/HOLD/OVF)
//   running  : 1 in RUN
//   overflow : 1 in OVF
module bcd_timer_encoder
    import vfsd_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned TICK_HZ     = 1_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] cont_3,
    output logic [3:0] cont_2,
    output logic [3:0] cont_1,
    output logic [3:0] cont_0,
    output logic       arm,
    output logic       running,
    output logic       overflow
);

    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, TICK_HZ);
    localparam int unsigned PW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("bcd_timer_encoder: CLK_FREQ_HZ/TICK_HZ must be at least 2");
    end

    timer_state_t  state_q;
    logic          arm_q;
    logic          running_q;
    logic          overflow_q;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    bcd_digit_t    digit [4];
    logic [3:0]    carry;
    logic [3:0]    inc;
    logic          tick;
    logic          saturated;
    logic          clr;
    logic          ovf_evt;

    assign tick      = (state_q == RUN) && (pre_q == PRE_LAST);
    assign saturated = (digit[0] == BCD_MAX) && (digit[1] == BCD_MAX) &&
                       (digit[2] == BCD_MAX) && (digit[3] == BCD_MAX);
    assign clr       = start && (state_q != RUN);

    // Gating the chain input at 9999 is what holds the digits saturated.
    // The terminal carry is folded into the overflow condition so that any
    // carry escaping the top digit still forces OVF rather than a silent wrap.
    assign inc[0]  = tick && !saturated;
    assign inc[1]  = carry[0];
    assign inc[2]  = carry[1];
    assign inc[3]  = carry[2];
    assign ovf_evt = (tick && saturated) || carry[3];

    for (genvar g = 0; g < 4; g++) begin : g_digit
        bcd_digit_counter u_digit (
            .clk       (clk),
            .reset     (reset),
            .clr       (clr),
            .inc       (inc[g]),
            .digit     (digit[g]),
            .carry_out (carry[g])
        );
    end

    always_comb begin
        pre_d = pre_q;
        if (state_q == RUN) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end else if (clr) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // Stop is checked before overflow so a stop landing on the 9999 tick
    // ends in HOLD with the saturated value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            arm_q      <= 1'b0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HOLD, OVF: begin
                    if (start) begin
                        state_q    <= RUN;
                        arm_q      <= 1'b1;
                        running_q  <= 1'b1;
                        overflow_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q   <= HOLD;
                        running_q <= 1'b0;
                    end else if (ovf_evt) begin
                        state_q    <= OVF;
                        running_q  <= 1'b0;
                        overflow_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    arm_q      <= 1'b0;
                    running_q  <= 1'b0;
                    overflow_q <= 1'b0;
                end
            endcase
        end
    end

    assign cont_3   = digit[3];
    assign cont_2   = digit[2];
    assign cont_1   = digit[1];
    assign cont_0   = digit[0];
    assign arm      = arm_q;
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule
